// File: rtl/mp3_frame_sync_if.sv
// mp3_frame_sync_if: raw input byte stream and aligned output frame stream
//   axiid/axiiv : raw stream byte and valid (source -> aligner)
//   axiod/axiov : aligned frame byte and valid (aligner -> parser)
//   sof/eof     : first/last byte markers of each forwarded frame
//   master: stream source and frame sink side; slave: the aligner
interface mp3_frame_sync_if;
  logic [7:0] axiid;
  logic       axiiv;
  logic [7:0] axiod;
  logic       axiov;
  logic       sof;
  logic       eof;
  modport master(output axiid, axiiv, input axiod, axiov, sof, eof);
  modport slave(input axiid, axiiv, output axiod, axiov, sof, eof);
endinterface

// File: rtl/mp3_frame_sync.sv
// mp3_frame_sync: aligns a raw MP3 byte stream to MPEG-1 Layer III 44.1 kHz frames
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : axiid/axiiv in; axiod/axiov/sof/eof out, registered
//   locked          : high while forwarding aligned frames
//   sync_lost       : one-cycle pulse when a predicted header is missing
//   frame_count     : frames forwarded since reset (wraps)
//   skip_count      : stream bytes discarded since reset (saturates)
//   Define LOCK_CONFIRM_EN to require a second header at the predicted position
//   before any frame is forwarded.
module mp3_frame_sync #(
  parameter int COUNT_W     = 16,
  parameter bit CHECK_LAYER = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mp3_frame_sync_if.slave    bus,
  output logic               locked,
  output logic               sync_lost,
  output logic [COUNT_W-1:0] frame_count,
  output logic [COUNT_W-1:0] skip_count
);
`ifdef LOCK_CONFIRM_EN
  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;
`else
  typedef enum logic {HUNT, LOCKED} state_t;
`endif
  state_t state_q, state_d;
  logic [31:0] w_q, w_d;
  logic [3:0] v_q, v_d;
  logic [10:0] rem_q, rem_d, n_len;
  logic first_q, first_d;
  logic [7:0] axiod_q, axiod_d;
  logic axiov_q, axiov_d, sof_q, sof_d, eof_q, eof_d, lost_q, lost_d;
  logic [COUNT_W-1:0] fc_q, fc_d, sc_q, sc_d;
  logic hv;
  function automatic logic [10:0] frame_len(input logic [3:0] idx);
    case (idx)
      4'd1:    frame_len = 11'd104;
      4'd2:    frame_len = 11'd130;
      4'd3:    frame_len = 11'd156;
      4'd4:    frame_len = 11'd182;
      4'd5:    frame_len = 11'd208;
      4'd6:    frame_len = 11'd261;
      4'd7:    frame_len = 11'd313;
      4'd8:    frame_len = 11'd365;
      4'd9:    frame_len = 11'd417;
      4'd10:   frame_len = 11'd522;
      4'd11:   frame_len = 11'd626;
      4'd12:   frame_len = 11'd731;
      4'd13:   frame_len = 11'd835;
      4'd14:   frame_len = 11'd1044;
      default: frame_len = 11'd0;
    endcase
  endfunction
  // header checks look at the window as it stands after this beat's shift
  assign w_d   = {w_q[23:0], bus.axiid};
  assign v_d   = {v_q[2:0], 1'b1};
  assign hv    = &v_d && w_d[31:21] == 11'h7FF && (!CHECK_LAYER || w_d[20:17] == 4'b1101) &&
                 w_d[15:12] != 4'h0 && w_d[15:12] != 4'hF && w_d[11:10] == 2'b00;
  assign n_len = frame_len(w_d[15:12]) + {10'd0, w_d[9]};
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    first_d = first_q;
    axiod_d = axiod_q;
    axiov_d = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    lost_d  = 1'b0;
    fc_d    = fc_q;
    sc_d    = sc_q;
    if (bus.axiiv) begin
      // outside LOCKED every valid byte pushed out of the window is discarded
      if (state_q != LOCKED && v_q[3] && !(&sc_q)) sc_d = sc_q + 1'b1;
      case (state_q)
        HUNT: begin
          rem_d   = n_len;
          first_d = 1'b1;
`ifdef LOCK_CONFIRM_EN
          state_d = hv ? CONFIRM : HUNT;
`else
          state_d = hv ? LOCKED : HUNT;
`endif
        end
`ifdef LOCK_CONFIRM_EN
        CONFIRM: begin
          rem_d = rem_q - 11'd1;
          if (rem_q == 11'd1) begin
            rem_d   = n_len;
            first_d = 1'b1;
            state_d = hv ? LOCKED : HUNT;
          end
        end
`endif
        default: begin
          axiod_d = w_q[31:24];
          axiov_d = 1'b1;
          sof_d   = first_q;
          first_d = 1'b0;
          rem_d   = rem_q - 11'd1;
          // last byte: the post-shift window is exactly where the next header must be
          if (rem_q == 11'd1) begin
            eof_d   = 1'b1;
            fc_d    = fc_q + 1'b1;
            rem_d   = n_len;
            first_d = hv;
            lost_d  = !hv;
            state_d = hv ? LOCKED : HUNT;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      w_q     <= '0;
      v_q     <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      axiod_q <= '0;
      axiov_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      lost_q  <= 1'b0;
      fc_q    <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      axiod_q <= axiod_d;
      axiov_q <= axiov_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      lost_q  <= lost_d;
      fc_q    <= fc_d;
      sc_q    <= sc_d;
      if (bus.axiiv) begin
        w_q <= w_d;
        v_q <= v_d;
      end
    end
  end
  assign bus.axiod   = axiod_q;
  assign bus.axiov   = axiov_q;
  assign bus.sof     = sof_q;
  assign bus.eof     = eof_q;
  assign locked      = state_q == LOCKED;
  assign sync_lost   = lost_q;
  assign frame_count = fc_q;
  assign skip_count  = sc_q;
endmodule

// File: tb/tb_mp3_frame_sync.sv
// tb_mp3_frame_sync: self-checking bench for mp3_frame_sync (default build)
`timescale 1ns/1ps
module tb_mp3_frame_sync;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic locked, sync_lost;
  logic [15:0] frame_count, skip_count;
  mp3_frame_sync_if bus();
  mp3_frame_sync #(.COUNT_W(16), .CHECK_LAYER(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .locked(locked), .sync_lost(sync_lost),
    .frame_count(frame_count), .skip_count(skip_count));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] hdr;
    logic        lock;
    int          len;
  } vec_t;
  int tests = 0;
  int fails = 0;
  logic [7:0] stim_q[$];
  logic [9:0] exp_q[$], got_q[$], s1_got[$];
  int exp_skip, exp_fc, exp_lost;
  logic exp_lk;
  int lost_cnt, lost_dbl, idle_viol;
  logic iv_prev = 1'b0, lost_prev = 1'b0;
  int lens[16] = '{0, 104, 130, 156, 182, 208, 261, 313, 365, 417, 522, 626, 731, 835, 1044, 0};
  // output monitor: records {sof,eof,byte} of every forwarded beat
  always @(negedge clk) begin
    if (!rst_n) begin
      iv_prev   = 1'b0;
      lost_prev = 1'b0;
    end else begin
      if (bus.axiov) begin
        got_q.push_back({bus.sof, bus.eof, bus.axiod});
        if (!iv_prev) idle_viol++;
      end else if (bus.sof || bus.eof) idle_viol++;
      if (sync_lost) begin
        lost_cnt++;
        if (lost_prev) lost_dbl++;
      end
      lost_prev = sync_lost;
      iv_prev   = bus.axiiv;
    end
  end
  task automatic check(input string nm, input logic signed [31:0] got, input logic signed [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic clear_mon();
    got_q.delete();
    lost_cnt  = 0;
    lost_dbl  = 0;
    idle_viol = 0;
  endtask
  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.axiiv = 1'b0;
    bus.axiid = 8'h00;
    clear_mon();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
      bus.axiiv = 1'b0;
      bus.axiid = 8'($urandom);
    end
    @(posedge clk);
    #1;
    bus.axiiv = 1'b1;
    bus.axiid = b;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 bus.axiiv = 1'b0;
    end
  endtask
  function automatic logic hdr_ok(input int p);
    logic [7:0] b0, b1, b2;
    b0 = stim_q[p];
    b1 = stim_q[p+1];
    b2 = stim_q[p+2];
    return b0 == 8'hFF && b1[7:5] == 3'b111 && b1[4:1] == 4'b1101 &&
           b2[7:4] != 4'h0 && b2[7:4] != 4'hF && b2[3:2] == 2'b00;
  endfunction
  function automatic int flen(input int p);
    logic [7:0] b2;
    b2 = stim_q[p+2];
    return lens[b2[7:4]] + int'(b2[1]);
  endfunction
  // reference: scan the whole stream for headers, follow predicted frame
  // boundaries; a byte leaves the aligner only once 4 newer bytes have arrived
  task automatic model();
    int L, q, p, n;
    L = stim_q.size();
    q = 0;
    exp_q.delete();
    exp_skip = 0;
    exp_fc   = 0;
    exp_lost = 0;
    exp_lk   = 1'b0;
    forever begin
      p = q;
      while (p + 3 < L && !hdr_ok(p)) p++;
      if (p + 3 >= L) begin
        exp_skip += (L - 4 > q) ? L - 4 - q : 0;
        exp_lk = 1'b0;
        return;
      end
      exp_skip += p - q;
      exp_lk = 1'b1;
      forever begin
        n = flen(p);
        for (int j = 0; j < n; j++)
          if (p + j + 4 < L) exp_q.push_back({j == 0, j == n - 1, stim_q[p+j]});
        if (p + n + 4 > L) return;
        exp_fc++;
        p += n;
        if (!hdr_ok(p)) break;
      end
      exp_lost++;
      exp_lk = 1'b0;
      q = p;
    end
  endtask
  function automatic logic [9:0] rec(input int i);
    return (i < got_q.size()) ? got_q[i] : 10'h000;
  endfunction
  function automatic int eof_cnt();
    int c = 0;
    foreach (got_q[i]) if (got_q[i][8]) c++;
    return c;
  endfunction
  task automatic run_stream(input int maxgap, input logic do_reset);
    if (do_reset) reset_dut();
    foreach (stim_q[i]) send(stim_q[i], $urandom_range(0, maxgap));
  endtask
  task automatic compare_run(input string nm);
    int bad = -1;
    idle(3);
    model();
    check({nm, " out_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    check($sformatf("%s first_bad_beat (got %h exp %h)", nm, rec(bad < 0 ? 0 : bad),
          bad < 0 ? 10'h0 : exp_q[bad]), bad, -1);
    check({nm, " skip_count"}, skip_count, exp_skip);
    check({nm, " frame_count"}, frame_count, exp_fc);
    check({nm, " locked"}, locked, exp_lk);
    check({nm, " sync_lost_pulses"}, lost_cnt, exp_lost);
    check({nm, " sync_lost_width"}, lost_dbl, 0);
    check({nm, " axiov_after_idle"}, idle_viol, 0);
  endtask
  task automatic push_hdr(input logic [31:0] h);
    for (int k = 3; k >= 0; k--) stim_q.push_back(h[8*k +: 8]);
  endtask
  task automatic build_s1();
    stim_q.delete();
    stim_q.push_back(8'h00);
    stim_q.push_back(8'h12);
    push_hdr(32'hFFFB9000);
    for (int i = 0; i < 413; i++) stim_q.push_back(8'(i + 1));
    push_hdr(32'hFFFB9200);
    for (int i = 0; i < 414; i++) stim_q.push_back(8'(3 * i));
    push_hdr(32'hFFFB9000);
  endtask
  task automatic gen_random();
    int idx, pad;
    stim_q.delete();
    repeat ($urandom_range(3, 6)) begin
      case ($urandom_range(0, 3))
        0: repeat ($urandom_range(0, 12)) stim_q.push_back(8'($urandom));
        3: push_hdr({16'hFFFB, ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0, 12'h000});
        default: begin
          idx = $urandom_range(1, 8);
          pad = $urandom_range(0, 1);
          stim_q.push_back(8'hFF);
          stim_q.push_back(($urandom_range(0, 1) != 0) ? 8'hFB : 8'hFA);
          stim_q.push_back({4'(idx), 2'b00, 1'(pad), 1'($urandom)});
          stim_q.push_back(8'($urandom));
          repeat (lens[idx] + pad - 4) stim_q.push_back(8'($urandom));
        end
      endcase
    end
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t vt[11];
    logic [31:0] hb;
    int same;
    bus.axiiv = 1'b0;
    bus.axiid = 8'h00;
    vt = '{
      '{32'hFFFB9000, 1'b1, 417},
      '{32'hFFFB9200, 1'b1, 418},
      '{32'hFFFB1000, 1'b1, 104},
      '{32'hFFFAE2C4, 1'b1, 1045},
      '{32'hFFFB6000, 1'b1, 261},
      '{32'hFFFBF000, 1'b0, 0},
      '{32'hFFFB0400, 1'b0, 0},
      '{32'hFFFB9400, 1'b0, 0},
      '{32'hFFF39000, 1'b0, 0},
      '{32'hFFFD9000, 1'b0, 0},
      '{32'hFEFB9000, 1'b0, 0}};
    reset_dut();
    check("reset flags", {bus.axiov, bus.sof, bus.eof, locked, sync_lost}, 0);
    check("reset counters", {frame_count, skip_count}, 0);
    check("reset axiod", bus.axiod, 0);
    for (int i = 0; i < 11; i++) begin
      reset_dut();
      hb = vt[i].hdr;
      for (int k = 3; k >= 0; k--) send(hb[8*k +: 8], 0);
      idle(1);
      check($sformatf("vec%0d locked_after_header", i), locked, vt[i].lock);
      if (vt[i].lock) begin
        repeat (vt[i].len) send(8'h00, 0);
        idle(3);
        check($sformatf("vec%0d frame_bytes", i), got_q.size(), vt[i].len);
        check($sformatf("vec%0d eof_count", i), eof_cnt(), 1);
        check($sformatf("vec%0d sof_first", i), rec(0), 10'h2FF);
        check($sformatf("vec%0d eof_last", i), rec(vt[i].len - 1), 10'h100);
        check($sformatf("vec%0d sync_lost", i), lost_cnt, 1);
      end else begin
        repeat (8) send(8'h00, 0);
        idle(3);
        check($sformatf("vec%0d no_output", i), got_q.size(), 0);
        check($sformatf("vec%0d still_hunting", i), locked, 0);
      end
    end
    build_s1();
    run_stream(0, 1'b1);
    compare_run("s1");
    check("s1 total_beats", got_q.size(), 835);
    check("s1 first_beat", rec(0), 10'h2FF);
    check("s1 eof_beat417", rec(416) & 10'h100, 10'h100);
    check("s1 sof_beat418", rec(417), 10'h2FF);
    check("s1 eof_beat835", rec(834) & 10'h100, 10'h100);
    check("s1 skip", skip_count, 2);
    check("s1 frames", frame_count, 2);
    check("s1 locked", locked, 1);
    s1_got = got_q;
    stim_q.delete();
    stim_q.push_back(8'h00);
    stim_q.push_back(8'h12);
    push_hdr(32'hFFFB9000);
    repeat (413) stim_q.push_back(8'hA5);
    push_hdr(32'h00000000);
    repeat (10) stim_q.push_back(8'h55);
    run_stream(0, 1'b1);
    compare_run("s2");
    check("s2 sync_lost_once", lost_cnt, 1);
    check("s2 locked", locked, 0);
    check("s2 beats", got_q.size(), 417);
    check("s2 skip", skip_count, 12);
    stim_q.delete();
    push_hdr(32'hFFFBF000);
    push_hdr(32'hFFFB0400);
    push_hdr(32'hFFFB9400);
    run_stream(0, 1'b1);
    compare_run("s3");
    check("s3 skip", skip_count, 8);
    check("s3 frames", frame_count, 0);
    check("s3 locked", locked, 0);
    build_s1();
    run_stream(5, 1'b1);
    compare_run("s4");
    same = (got_q.size() == s1_got.size()) ? 1 : 0;
    foreach (s1_got[i]) if (rec(i) !== s1_got[i]) same = 0;
    check("s4 same_as_s1", same, 1);
    stim_q.delete();
    stim_q.push_back(8'h00);
    stim_q.push_back(8'h12);
    push_hdr(32'hFFFB9000);
    repeat (100) stim_q.push_back(8'h3C);
    run_stream(2, 1'b1);
    compare_run("s5 pre");
    check("s5 no_eof_pre", eof_cnt(), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #0.5;
    check("s5 async_flags", {bus.axiov, bus.sof, bus.eof, locked, sync_lost}, 0);
    check("s5 async_counters", {frame_count, skip_count}, 0);
    #0.5 rst_n = 1'b1;
    clear_mon();
    build_s1();
    run_stream(0, 1'b0);
    compare_run("s5 relock");
    check("s5 relock_first_beat", rec(0), 10'h2FF);
    for (int r = 0; r < 5; r++) begin
      gen_random();
      run_stream(1, 1'b1);
      compare_run($sformatf("rand%0d", r));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mp3_frame_sync.md
Name: mp3_frame_sync

Overview:
- Byte-stream aligner directly upstream of the header parser.
- Scans the raw MP3 byte stream for an MPEG-1 Layer III 44.1 kHz sync header and computes the frame length.
- Forwards only whole, aligned frames (header bytes first) with start/end markers, so the downstream header/side-info stages always see byte 0 of a frame first.
- Tracks lock: each predicted next-frame position is checked for a valid header.

Parameters:
- COUNT_W, 16, width of frame_count and skip_count status counters.
- CHECK_LAYER, 1, when 1 the header must carry MPEG-1 (w[20:19]=11) and Layer III (w[18:17]=01); when 0 those bits are ignored.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- axiid  in  8  raw stream byte
- axiiv  in  1  axiid valid; no backpressure, every valid beat is consumed
- axiod  out  8  aligned frame byte
- axiov  out  1  axiod valid
- sof  out  1  high with the first header byte of each forwarded frame
- eof  out  1  high with the last byte of each forwarded frame
- locked  out  1  high while in LOCKED
- sync_lost  out  1  one-cycle pulse when a predicted header fails the check
- frame_count  out  COUNT_W  frames forwarded since reset, wraps
- skip_count  out  COUNT_W  stream bytes discarded since reset, saturates at all-ones

Behaviour:
- Reset: rst_n low asynchronously clears all state. State=HUNT; delay line and stage-valid bits cleared; all outputs 0.
- Delay line: 4-byte shift register with a per-stage valid bit. It shifts only on axiiv beats.
- Header window: w[31:0], oldest byte in w[31:24], evaluated on the post-shift contents of each valid beat, i.e. including the byte accepted that beat.
- Header valid when all of the following hold:
  - all 4 stages valid
  - w[31:21]=11'h7FF
  - layer bits per CHECK_LAYER
  - bitrate index w[15:12] not 0000 and not 1111
  - w[11:10]=00
- Frame length N comes from the bitrate index (1..14) via LUT: 104,130,156,182,208,261,313,365,417,522,626,731,835,1044. Add 1 when w[9]=1. The remaining-byte counter is 11 bits.
- All outputs are registered and update the cycle after an input beat. Cycles with axiiv=0 force axiov=sof=eof=0 and leave state unchanged.
- HUNT:
  - Each valid beat shifts the window.
  - If the oldest byte being shifted out is valid, it is discarded and skip_count increments.
  - On a valid header: load remaining=N and go to LOCKED.
- LOCKED:
  - Each valid beat outputs the pre-shift oldest byte on axiod with axiov=1, then decrements remaining.
  - The first byte after a load has sof=1.
  - When remaining=1, that byte has eof=1 and frame_count increments.
- Latency: byte k of a frame appears 4 valid beats after it was accepted, plus 1 cycle.
- Eof beat: the post-shift window holds the next 4 bytes.
  - If the header is valid: reload N and stay LOCKED. Frames are back-to-back with no gap beat.
  - If invalid: sync_lost pulses, go to HUNT, and the window keeps sliding. Those bytes may seed the next search.
- Reset mid-frame abandons the frame; no eof is emitted.
- Trailing bytes (up to 4) stay buffered until further valid beats arrive.

Optional Feature:
- Macro: LOCK_CONFIRM_EN.
- Defined: a HUNT detection goes to CONFIRM instead of LOCKED.
  - CONFIRM loads remaining=N, outputs nothing, and counts discarded bytes into skip_count.
  - At remaining=1, the window check runs. Valid: reload and go to LOCKED, forwarding from that header (sof on its first byte). Invalid: back to HUNT with no sync_lost pulse.
  - The first detected frame is never forwarded.
- Undefined: the CONFIRM state does not exist and the first valid header is forwarded immediately.

Test Plan:
1. Reset, then stream 00 12, FF FB 90 00, 413 filler bytes, FF FB 92 00, 414 filler bytes, FF FB 90 00 -> sof on the first FF. First eof on output byte 417. Second frame forwarded with sof immediately following and eof on byte 418. skip_count=2, frame_count=2, locked=1.
2. After a 417-byte frame, feed 00 00 00 00 where the next header is expected -> sync_lost high for exactly 1 cycle, locked=0, axiov stays 0 until a new valid header.
3. Feed FF FB F0 00, FF FB 04 00, FF FB 94 00 (bitrate 15, bitrate 0, 48 kHz) -> no lock. skip_count counts every byte shifted out; frame_count=0.
4. Repeat scenario 1 with axiiv randomly deasserted 0-5 cycles between bytes -> identical axiod/sof/eof byte sequence. axiov is never high on a cycle following an idle input cycle.
5. Drive rst_n low mid-frame for 1 ns between clock edges -> all outputs 0 immediately, no eof. After release, the next valid header relocks.
6. With LOCK_CONFIRM_EN, run scenario 1 -> the first 417-byte frame is not output. The first sof is on the FF FB 92 00 frame. skip_count=2+417, frame_count=1.
